// File: rtl/cpu_pkg.sv
// ------------------------------------------------------------------
// cpu_pkg: condition codes and NZCV flag type shared by the CPU units
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

`default_nettype wire

// File: rtl/cond_eval.sv
// ------------------------------------------------------------------
// cond_eval: combinational A64 condition-code evaluation against NZCV
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module cond_eval
  import cpu_pkg::*;
(
  input  nzcv_t i_flags,
  input  cond_e i_cond,
  output logic  o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ: o_taken = i_flags.z;
      COND_NE: o_taken = !i_flags.z;
      COND_HS: o_taken = i_flags.c;
      COND_LO: o_taken = !i_flags.c;
      COND_MI: o_taken = i_flags.n;
      COND_PL: o_taken = !i_flags.n;
      COND_VS: o_taken = i_flags.v;
      COND_VC: o_taken = !i_flags.v;
      COND_HI: o_taken = i_flags.c && !i_flags.z;
      COND_LS: o_taken = !i_flags.c || i_flags.z;
      COND_GE: o_taken = (i_flags.n == i_flags.v);
      COND_LT: o_taken = (i_flags.n != i_flags.v);
      COND_GT: o_taken = !i_flags.z && (i_flags.n == i_flags.v);
      COND_LE: o_taken = i_flags.z || (i_flags.n != i_flags.v);
      // NV behaves as "always" in A64, unlike A32
      COND_AL: o_taken = 1'b1;
      COND_NV: o_taken = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/flag_cond_unit.sv
// ------------------------------------------------------------------
// flag_cond_unit: NZCV register, in-flight setter tracking and branch
// condition evaluation with same-cycle EX bypass. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module flag_cond_unit
  import cpu_pkg::*;
#(
  parameter int PEND_MAX = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flag_wr_en,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_carry_out,
  input  logic       alu_overflow,
  input  logic       setter_issue,
  input  logic       flush,
  input  logic       br_req_valid,
  input  logic [3:0] br_cond,
  output logic       br_req_ready,
  output logic       br_resp_valid,
  output logic       br_taken,
  output logic [3:0] flags_q,
  output logic       pend_err
);

  localparam int               CNT_W      = $clog2(PEND_MAX + 1);
  localparam logic [CNT_W-1:0] C_PEND_MAX = CNT_W'(PEND_MAX);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  nzcv_t            r_flags;
  logic [CNT_W-1:0] r_pend_cnt;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             r_pend_err;
  logic             r_resp_valid;
  logic             r_taken;

  nzcv_t            w_alu_flags;
  nzcv_t            w_eff_flags;
  logic             w_accept;
  logic             w_taken;
  logic             w_overrun;

  assign w_alu_flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
  assign w_eff_flags = flag_wr_en ? w_alu_flags : r_flags;

  // Only safe to branch once no older setter is outstanding, or the last one
  // is writing right now and its flags are bypassed.
  assign br_req_ready = !flush &&
                        ((r_pend_cnt == '0) || ((r_pend_cnt == C_ONE) && flag_wr_en));
  assign w_accept     = br_req_valid && br_req_ready;
  assign w_overrun    = setter_issue && (r_pend_cnt == C_PEND_MAX);

  cond_eval u_cond_eval (
    .i_flags (w_eff_flags),
    .i_cond  (cond_e'(br_cond)),
    .o_taken (w_taken)
  );

  always_comb begin
    w_pend_nxt = r_pend_cnt;
    if (flush) begin
      w_pend_nxt = '0;
    end else if (setter_issue && !flag_wr_en) begin
      if (r_pend_cnt != C_PEND_MAX) w_pend_nxt = r_pend_cnt + C_ONE;
    end else if (flag_wr_en && !setter_issue) begin
      if (r_pend_cnt != '0) w_pend_nxt = r_pend_cnt - C_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags      <= '0;
      r_pend_cnt   <= '0;
      r_pend_err   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_taken      <= 1'b0;
    end else begin
      if (flag_wr_en) r_flags <= w_alu_flags;
      r_pend_cnt   <= w_pend_nxt;
      if (w_overrun) r_pend_err <= 1'b1;
      r_resp_valid <= w_accept;
      if (w_accept) r_taken <= w_taken;
    end
  end

  assign br_resp_valid = r_resp_valid;
  assign br_taken      = r_taken;
  assign flags_q       = r_flags;
  assign pend_err      = r_pend_err;

endmodule

`default_nettype wire
